// File: rtl/pwm_button_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_button_ctrl_pkg
// Purpose  : Shared FSM state encodings and default timing constants for the
//            PWM push-button control stage.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_button_ctrl_pkg;

    // FSM state encodings (3-bit)
    localparam int unsigned c_ST_W = 3;
    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_HOLD_UP   = 3'd1;
    localparam logic [2:0] c_ST_HOLD_DN   = 3'd2;
    localparam logic [2:0] c_ST_REPEAT_UP = 3'd3;
    localparam logic [2:0] c_ST_REPEAT_DN = 3'd4;
    localparam logic [2:0] c_ST_LOCK      = 3'd5;

    // Default timing constants
    localparam int c_DEF_DEBOUNCE_CYCLES = 1000;
    localparam int c_DEF_REPEAT_DELAY    = 500000;
    localparam int c_DEF_REPEAT_RATE     = 100000;
    localparam int c_DEF_CNT_W           = 20;

endpackage
`default_nettype wire

// File: rtl/pwm_button_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_button_ctrl_if
// Purpose  : Groups the button inputs, PWM update strobe and the request
//            outputs of the control stage.
//            master : drives buttons/step_tick, observes requests
//            slave  : the control stage itself
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_button_ctrl_if;
    logic btn_up;
    logic btn_down;
    logic step_tick;
    logic duty_inc;
    logic duty_dec;
    logic busy;

    modport master (
        output btn_up,
        output btn_down,
        output step_tick,
        input  duty_inc,
        input  duty_dec,
        input  busy
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        input  step_tick,
        output duty_inc,
        output duty_dec,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/pwm_button_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : 2-FF synchroniser followed by a stable-level counter. The
//            debounced level only follows the synchronised level after it
//            has differed for DEBOUNCE_CYCLES consecutive samples.
// Ports    : clk, rst (sync, active-high), btn_raw (async in),
//            btn_db (debounced level)
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
    import pwm_button_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = c_DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_db) begin
                // The flip happens on the DEBOUNCE_CYCLES-th consecutive
                // differing sample; the counter never exceeds c_CNT_LAST.
                if (r_cnt == c_CNT_LAST) begin
                    r_db  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign btn_db = r_db;

endmodule
`default_nettype wire

// File: rtl/pwm_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_button_ctrl
// Purpose  : Turns raw up/down push-buttons into level-held duty_inc /
//            duty_dec requests for the PWM generator, with debounce,
//            auto-repeat while held, and hold-until-consumed handshaking
//            against the PWM update strobe.
// Ports    : clk, rst (sync, active-high)
//            bus.btn_up / bus.btn_down : raw async buttons, active-high
//            bus.step_tick             : PWM update strobe, consumes request
//            bus.duty_inc / duty_dec   : pending requests
//            bus.busy                  : either request pending
// Revision : 1.0 - initial release
// ============================================================================
module pwm_button_ctrl
    import pwm_button_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = c_DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = c_DEF_REPEAT_RATE,
    parameter int CNT_W           = c_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    pwm_button_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] c_REPEAT_DELAY = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] c_RATE_LAST    = CNT_W'(REPEAT_RATE - 1);

    logic              w_db_up;
    logic              w_db_dn;
    logic              r_db_up_d;
    logic              r_db_dn_d;
    logic              w_up_rise;
    logic              w_dn_rise;

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_nxt;

    logic [CNT_W-1:0]  r_rep_cnt;
    logic              w_delay_hit;
    logic              w_rate_hit;
    logic              w_rep_run;

    logic              w_issue_up;
    logic              w_issue_dn;
    logic              r_req_up;
    logic              r_req_dn;

    // ------------------------------------------------------------------
    // Per-button synchronise + debounce
    // ------------------------------------------------------------------
    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_up (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.btn_up),
        .btn_db  (w_db_up)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_dn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.btn_down),
        .btn_db  (w_db_dn)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_up_d <= 1'b0;
            r_db_dn_d <= 1'b0;
        end else begin
            r_db_up_d <= w_db_up;
            r_db_dn_d <= w_db_dn;
        end
    end

    assign w_up_rise = w_db_up & ~r_db_up_d;
    assign w_dn_rise = w_db_dn & ~r_db_dn_d;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_delay_hit = (r_rep_cnt == c_REPEAT_DELAY);
    assign w_rate_hit  = (r_rep_cnt == c_RATE_LAST);

    // ------------------------------------------------------------------
    // FSM: next-state logic. In HOLD/REPEAT the opposite button takes
    // priority over release so a crossed press always ends in LOCK.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_up_rise && w_dn_rise) begin
                    w_state_nxt = c_ST_LOCK;
                end else if (w_up_rise) begin
                    w_state_nxt = w_db_dn ? c_ST_LOCK : c_ST_HOLD_UP;
                end else if (w_dn_rise) begin
                    w_state_nxt = w_db_up ? c_ST_LOCK : c_ST_HOLD_DN;
                end
            end
            c_ST_HOLD_UP: begin
                if (w_db_dn)           w_state_nxt = c_ST_LOCK;
                else if (!w_db_up)     w_state_nxt = c_ST_IDLE;
                else if (w_delay_hit)  w_state_nxt = c_ST_REPEAT_UP;
            end
            c_ST_HOLD_DN: begin
                if (w_db_up)           w_state_nxt = c_ST_LOCK;
                else if (!w_db_dn)     w_state_nxt = c_ST_IDLE;
                else if (w_delay_hit)  w_state_nxt = c_ST_REPEAT_DN;
            end
            c_ST_REPEAT_UP: begin
                if (w_db_dn)           w_state_nxt = c_ST_LOCK;
                else if (!w_db_up)     w_state_nxt = c_ST_IDLE;
            end
            c_ST_REPEAT_DN: begin
                if (w_db_up)           w_state_nxt = c_ST_LOCK;
                else if (!w_db_dn)     w_state_nxt = c_ST_IDLE;
            end
            c_ST_LOCK: begin
                if (!w_db_up && !w_db_dn) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Issues are tied to the transitions so that leaving a
    // state (release or LOCK) can never coincide with a new request.
    // w_rep_run keeps the repeat counter counting; every other cycle
    // (issue, IDLE, LOCK, exit) clears it.
    // ------------------------------------------------------------------
    always_comb begin
        w_issue_up = 1'b0;
        w_issue_dn = 1'b0;
        w_rep_run  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_issue_up = (w_state_nxt == c_ST_HOLD_UP);
                w_issue_dn = (w_state_nxt == c_ST_HOLD_DN);
            end
            c_ST_HOLD_UP: begin
                w_issue_up = (w_state_nxt == c_ST_REPEAT_UP);
                w_rep_run  = (w_state_nxt == c_ST_HOLD_UP);
            end
            c_ST_HOLD_DN: begin
                w_issue_dn = (w_state_nxt == c_ST_REPEAT_DN);
                w_rep_run  = (w_state_nxt == c_ST_HOLD_DN);
            end
            c_ST_REPEAT_UP: begin
                w_issue_up = (w_state_nxt == c_ST_REPEAT_UP) && w_rate_hit;
                w_rep_run  = (w_state_nxt == c_ST_REPEAT_UP) && !w_rate_hit;
            end
            c_ST_REPEAT_DN: begin
                w_issue_dn = (w_state_nxt == c_ST_REPEAT_DN) && w_rate_hit;
                w_rep_run  = (w_state_nxt == c_ST_REPEAT_DN) && !w_rate_hit;
            end
            default: begin
                w_issue_up = 1'b0;
                w_issue_dn = 1'b0;
                w_rep_run  = 1'b0;
            end
        endcase
    end

    // Repeat counter, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt <= '0;
        end else if (w_rep_run) begin
            if (r_rep_cnt != {CNT_W{1'b1}}) begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
            end
        end else begin
            r_rep_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Request flags. An issue beats a same-cycle step_tick, and a repeated
    // issue merges into the pending flag. A new request in one direction
    // cancels an unconsumed request in the other, as the two would net to
    // no change and must never be presented together.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_up <= 1'b0;
            r_req_dn <= 1'b0;
        end else if (w_issue_up) begin
            r_req_up <= 1'b1;
            r_req_dn <= 1'b0;
        end else if (w_issue_dn) begin
            r_req_up <= 1'b0;
            r_req_dn <= 1'b1;
        end else if (bus.step_tick) begin
            r_req_up <= 1'b0;
            r_req_dn <= 1'b0;
        end
    end

    assign bus.duty_inc = r_req_up;
    assign bus.duty_dec = r_req_dn;
    assign bus.busy     = r_req_up | r_req_dn;

endmodule
`default_nettype wire
